// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snn_pkg
// Description : Shared constants and types for the SNN blocks (encoder, LIF
//               layer, readout). Holds the datapath width, the input-layer
//               neuron count and the encoder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package snn_pkg;

    localparam int WIDTH_P           = 8;
    localparam int NUM_INPUT_NEURONS = 8;

    // Encoder states. LOAD doubles as the rest state.
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } enc_state_e;

endpackage : snn_pkg
`default_nettype wire

// File: rtl/spike_rate_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : spike_rate_encoder_if
// Description : Valid/ready byte stream carrying intensity values into the
//               spike rate encoder.
//   data  : intensity byte (channel 0 first)
//   valid : data is valid (driven by the source)
//   ready : sink accepts a byte this cycle
// Revision    : 1.0 - initial release
// ============================================================================
interface spike_rate_encoder_if
    import snn_pkg::*;
#(
    parameter int WIDTH_P = snn_pkg::WIDTH_P
);
    logic [WIDTH_P-1:0] data;
    logic               valid;
    logic               ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface : spike_rate_encoder_if
`default_nettype wire

// File: rtl/spike_rate_encoder_channel.sv
`default_nettype none
// ============================================================================
// Module      : spike_rate_channel
// Description : One encoder channel: intensity register, phase accumulator
//               and registered carry-out spike.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_en      : capture intensity_i
//   clear_acc    : zero the accumulator (start of a run)
//   step         : advance one timestep
//   intensity_i  : intensity byte to load
//   spike_o      : spike for the last step (0 when no step happened)
// Revision    : 1.0 - initial release
// ============================================================================
module spike_rate_channel
    import snn_pkg::*;
#(
    parameter int WIDTH_P = snn_pkg::WIDTH_P
) (
    input  wire logic               clk_i,
    input  wire logic               rst_i,
    input  wire logic               load_en,
    input  wire logic               clear_acc,
    input  wire logic               step,
    input  wire logic [WIDTH_P-1:0] intensity_i,
    output logic                    spike_o
);

    logic [WIDTH_P-1:0] intensity_q;
    logic [WIDTH_P-1:0] acc_q;
    logic               spike_q;
    logic [WIDTH_P:0]   w_sum;

    // Carry out of the accumulator is the spike; the low bits wrap.
    assign w_sum = {1'b0, acc_q} + {1'b0, intensity_q};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            intensity_q <= '0;
            acc_q       <= '0;
            spike_q     <= 1'b0;
        end else begin
            if (load_en) begin
                intensity_q <= intensity_i;
            end
            if (clear_acc) begin
                acc_q <= '0;
            end else if (step) begin
                acc_q <= w_sum[WIDTH_P-1:0];
            end
            spike_q <= step & w_sum[WIDTH_P];
        end
    end

    assign spike_o = spike_q;

endmodule : spike_rate_channel
`default_nettype wire

// File: rtl/spike_rate_encoder.sv
`default_nettype none
// ============================================================================
// Module      : spike_rate_encoder
// Description : Rate-coded spike encoder. Loads NUM_CHANNELS intensities over
//               a byte stream, then emits one spike vector per timestep for
//               WINDOW timesteps using per-channel phase accumulators.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   in_if         : intensity byte stream (slave side)
//   step_en_i     : timestep tick while running
//   spike_o       : spike vector for the current timestep
//   spike_valid_o : one-cycle strobe per timestep
//   busy_o        : a load is in progress or a run is active
//   done_o        : one-cycle pulse with the final spike vector
// Revision    : 1.0 - initial release
// ============================================================================
module spike_rate_encoder
    import snn_pkg::*;
#(
    parameter  int WIDTH_P      = snn_pkg::WIDTH_P,
    parameter  int NUM_CHANNELS = snn_pkg::NUM_INPUT_NEURONS,
    parameter  int WINDOW       = 256,
    localparam int CNT_W        = $clog2(WINDOW + 1)
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    spike_rate_encoder_if.slave    in_if,
    input  wire logic              step_en_i,
    output logic [NUM_CHANNELS-1:0] spike_o,
    output logic                   spike_valid_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    enc_state_e              state_q, state_d;
    logic [IDX_W-1:0]        load_idx_q, load_idx_d;
    logic [CNT_W-1:0]        step_cnt_q, step_cnt_d;
    logic                    spike_valid_q;

    logic                    w_ready;
    logic                    w_beat;
    logic                    w_last_beat;
    logic                    w_step;
    logic                    w_last_step;
    logic                    w_busy;
    logic [NUM_CHANNELS-1:0] w_spike;

    assign w_beat      = in_if.valid & w_ready;
    assign w_last_beat = w_beat & (load_idx_q == IDX_W'(NUM_CHANNELS - 1));
    assign w_step      = (state_q == ST_RUN) & step_en_i;
    assign w_last_step = w_step & (step_cnt_q == CNT_W'(WINDOW - 1));

    // ---------------- state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_LOAD;
            load_idx_q    <= '0;
            step_cnt_q    <= '0;
            spike_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_idx_q    <= load_idx_d;
            step_cnt_q    <= step_cnt_d;
            spike_valid_q <= w_step;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d    = state_q;
        load_idx_d = load_idx_q;
        step_cnt_d = step_cnt_q;
        unique case (state_q)
            ST_LOAD: begin
                if (w_beat) begin
                    load_idx_d = w_last_beat ? '0 : load_idx_q + 1'b1;
                end
                if (w_last_beat) begin
                    state_d    = ST_RUN;
                    step_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (w_step) begin
                    step_cnt_d = step_cnt_q + 1'b1;
                end
                if (w_last_step) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_LOAD;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // ---------------- output logic ----------------
    // All outputs read as idle while reset is being applied.
    always_comb begin
        w_ready = 1'b0;
        w_busy  = 1'b0;
        unique case (state_q)
            ST_LOAD: begin
                w_ready = 1'b1;
                w_busy  = (load_idx_q != '0);
            end
            ST_RUN:  w_busy = 1'b1;
            default: begin
                w_ready = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
        w_ready = w_ready & ~rst_i;
    end

    assign in_if.ready   = w_ready;
    assign busy_o        = w_busy & ~rst_i;
    assign done_o        = (state_q == ST_DONE) & ~rst_i;
    assign spike_valid_o = spike_valid_q & ~rst_i;
    assign spike_o       = w_spike & {NUM_CHANNELS{~rst_i}};

    // ---------------- channels ----------------
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        spike_rate_channel #(
            .WIDTH_P (WIDTH_P)
        ) u_chan (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .load_en     (w_beat & (load_idx_q == IDX_W'(c))),
            .clear_acc   (w_last_beat),
            .step        (w_step),
            .intensity_i (in_if.data),
            .spike_o     (w_spike[c])
        );
    end

endmodule : spike_rate_encoder
`default_nettype wire

// File: tb/tb_spike_rate_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_rate_encoder
// Description : Directed self-checking bench for spike_rate_encoder. Instance
//               A uses WINDOW=256, instance B uses WINDOW=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_rate_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_step = 1'b0, b_step = 1'b0;
    logic [7:0] a_spike, b_spike;
    logic       a_sv, a_busy, a_done;
    logic       b_sv, b_busy, b_done;

    spike_rate_encoder_if #(.WIDTH_P(8)) if_a ();
    spike_rate_encoder_if #(.WIDTH_P(8)) if_b ();

    spike_rate_encoder #(.WIDTH_P(8), .NUM_CHANNELS(8), .WINDOW(256)) dut_a (
        .clk_i(clk), .rst_i(rst), .in_if(if_a), .step_en_i(a_step),
        .spike_o(a_spike), .spike_valid_o(a_sv), .busy_o(a_busy), .done_o(a_done)
    );

    spike_rate_encoder #(.WIDTH_P(8), .NUM_CHANNELS(8), .WINDOW(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .in_if(if_b), .step_en_i(b_step),
        .spike_o(b_spike), .spike_valid_o(b_sv), .busy_o(b_busy), .done_o(b_done)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] vec1   [8];
    logic [7:0] vec255 [8];
    logic [7:0] vec200 [8];
    logic [7:0] vec_hs [8];
    int         cnt    [8];
    int         n_valid, n_done, n_coinc, n_stray;
    bit         got_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; a_step = 1'b0; b_step = 1'b0;
        if_a.valid = 1'b0; if_b.valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Push eight bytes into instance A (sel=0) or B (sel=1).
    task automatic load(input int sel, input logic [7:0] v [8]);
        int guard;
        for (int i = 0; i < 8; i++) begin
            guard = 0;
            if (sel == 0) begin
                if_a.data = v[i]; if_a.valid = 1'b1;
                while (!if_a.ready && guard < 50) begin tick(); guard++; end
            end else begin
                if_b.data = v[i]; if_b.valid = 1'b1;
                while (!if_b.ready && guard < 50) begin tick(); guard++; end
            end
            if (guard >= 50) begin
                n_checks++; n_fail++;
                $display("FAIL load_ready_timeout: ready stayed 0 for byte %0d (required 1)", i);
            end
            tick();
        end
        if_a.valid = 1'b0; if_b.valid = 1'b0;
    endtask

    // Step instance A once every 'period' cycles until done_o, tallying spikes.
    task automatic run_a(input int period, input int budget);
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        n_valid = 0; n_done = 0; n_coinc = 0; n_stray = 0; got_done = 1'b0;
        for (int cyc = 0; cyc < budget && !got_done; cyc++) begin
            a_step = (cyc % period == 0);
            tick();
            if (a_sv) begin
                n_valid++;
                for (int i = 0; i < 8; i++) cnt[i] += int'(a_spike[i]);
            end else if (a_spike != 8'h00) begin
                n_stray++;
            end
            if (a_sv && !a_step) n_stray++;
            if (a_done) begin
                n_done++; got_done = 1'b1;
                if (a_sv) n_coinc++;
            end
        end
        a_step = 1'b0;
        n_checks++;
        if (!got_done) begin
            n_fail++;
            $display("FAIL run_done_timeout: done_o not seen within %0d cycles (required a pulse)", budget);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (a_done) n_done++;
            if (a_sv) n_stray++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick();
        n_checks++;
        if ({if_a.ready, a_busy, a_done, a_sv, a_spike} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: ready/busy/done/valid/spike=%03h required 000",
                     {if_a.ready, a_busy, a_done, a_sv, a_spike});
        end
        rst = 1'b0; #1;
        n_checks++;
        if (if_a.ready !== 1'b1 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_load_state: ready=%b busy=%b required ready=1 busy=0", if_a.ready, a_busy);
        end
    endtask

    task automatic test_full_run();
        load(0, vec1);
        run_a(1, 400);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (cnt[i] != int'(vec1[i])) begin
                n_fail++;
                $display("FAIL full_run_count ch%0d: got %0d required %0d", i, cnt[i], vec1[i]);
            end
        end
        n_checks++;
        if (n_valid != 256) begin n_fail++; $display("FAIL full_run_valid_pulses: got %0d required 256", n_valid); end
        n_checks++;
        if (n_done != 1) begin n_fail++; $display("FAIL full_run_done_pulses: got %0d required 1", n_done); end
        n_checks++;
        if (n_coinc != 1) begin n_fail++; $display("FAIL full_run_done_with_last_spike: got %0d required 1", n_coinc); end
        n_checks++;
        if (n_stray != 0) begin n_fail++; $display("FAIL full_run_stray_valid: got %0d required 0", n_stray); end
    endtask

    task automatic test_timing();
        logic [3:0] expv;
        expv = 4'b1010;  // step 4..1 -> ch3 pattern 0,1,0,1 for steps 1..4
        load(0, vec1);
        n_checks++;
        if (a_sv !== 1'b0) begin n_fail++; $display("FAIL timing_idle_valid: got %b required 0", a_sv); end
        for (int k = 0; k < 4; k++) begin
            a_step = 1'b1; tick();
            n_checks++;
            if (a_sv !== 1'b1 || a_spike[3] !== expv[k]) begin
                n_fail++;
                $display("FAIL timing_step%0d: valid=%b spike3=%b required valid=1 spike3=%b", k + 1, a_sv, a_spike[3], expv[k]);
            end
            a_step = 1'b0; tick();
            n_checks++;
            if (a_sv !== 1'b0 || a_spike !== 8'h00) begin
                n_fail++;
                $display("FAIL timing_gap%0d: valid=%b spike=%02h required valid=0 spike=00", k + 1, a_sv, a_spike);
            end
        end
        run_a(1, 400);
        n_checks++;
        if (n_valid != 252 || n_done != 1) begin
            n_fail++;
            $display("FAIL timing_rest_of_run: valid=%0d done=%0d required 252 and 1", n_valid, n_done);
        end
    endtask

    task automatic test_handshake();
        int  beats, guard;
        logic v, pre_ready;
        beats = 0; guard = 0;
        while (beats < 8 && guard < 500) begin
            v = 1'($urandom_range(0, 1));
            if_a.valid = v; if_a.data = vec_hs[beats];
            pre_ready = if_a.ready;
            tick();
            if (v && pre_ready) beats++;
            guard++;
        end
        n_checks++;
        if (beats != 8) begin n_fail++; $display("FAIL handshake_beats: got %0d required 8", beats); end
        n_checks++;
        if (if_a.ready !== 1'b0 || a_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake_ready_drop: ready=%b busy=%b required ready=0 busy=1", if_a.ready, a_busy);
        end
        // Offer junk during the whole run; none of it may land.
        if_a.valid = 1'b1; if_a.data = 8'hFF;
        run_a(1, 400);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (cnt[i] != int'(vec_hs[i])) begin
                n_fail++;
                $display("FAIL handshake_run_count ch%0d: got %0d required %0d", i, cnt[i], vec_hs[i]);
            end
        end
        // valid held across DONE->LOAD: bytes taken from the first LOAD cycle.
        n_checks++;
        if (a_busy !== 1'b1 || if_a.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake_accept_after_done: busy=%b ready=%b required 1 and 1", a_busy, if_a.ready);
        end
        do_reset();
    endtask

    task automatic test_pacing();
        load(0, vec255);
        run_a(3, 2000);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (cnt[i] != 255) begin n_fail++; $display("FAIL pacing_count ch%0d: got %0d required 255", i, cnt[i]); end
        end
        n_checks++;
        if (n_stray != 0 || n_valid != 256 || n_done != 1) begin
            n_fail++;
            $display("FAIL pacing_strobes: stray=%0d valid=%0d done=%0d required 0,256,1", n_stray, n_valid, n_done);
        end
    endtask

    task automatic test_reset_mid_run();
        int dn, sv;
        load(0, vec1);
        a_step = 1'b1;
        repeat (100) tick();
        rst = 1'b1; tick(); rst = 1'b0; #1;
        n_checks++;
        if (a_spike !== 8'h00 || a_sv !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset_outputs: spike=%02h valid=%b busy=%b done=%b required all 0", a_spike, a_sv, a_busy, a_done);
        end
        dn = 0; sv = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (a_done) dn++;
            if (a_sv) sv++;
        end
        a_step = 1'b0;
        n_checks++;
        if (dn != 0 || sv != 0) begin
            n_fail++;
            $display("FAIL midrun_no_done: done=%0d valid=%0d required 0 and 0", dn, sv);
        end
        load(0, vec1);
        run_a(1, 400);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (cnt[i] != int'(vec1[i])) begin
                n_fail++;
                $display("FAIL midrun_rerun_count ch%0d: got %0d required %0d", i, cnt[i], vec1[i]);
            end
        end
    endtask

    task automatic test_small_window();
        logic [3:0] expv;
        expv = 4'b1110;  // steps 1..4 -> 0,1,1,1
        load(1, vec200);
        b_step = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (b_sv !== 1'b1 || b_spike !== {8{expv[k]}} || b_done !== (k == 3)) begin
                n_fail++;
                $display("FAIL small_window_step%0d: valid=%b spike=%02h done=%b required 1,%02h,%b",
                         k + 1, b_sv, b_spike, b_done, {8{expv[k]}}, (k == 3));
            end
        end
        b_step = 1'b0; tick();
        n_checks++;
        if (b_done !== 1'b0 || b_sv !== 1'b0 || if_b.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL small_window_after: done=%b valid=%b ready=%b required 0,0,1", b_done, b_sv, if_b.ready);
        end
    endtask

    initial begin
        vec1 = '{8'd0, 8'd1, 8'd64, 8'd128, 8'd192, 8'd254, 8'd255, 8'd37};
        vec_hs = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        for (int i = 0; i < 8; i++) begin vec255[i] = 8'd255; vec200[i] = 8'd200; end
        if_a.valid = 1'b0; if_a.data = 8'h00;
        if_b.valid = 1'b0; if_b.data = 8'h00;

        test_reset();
        test_full_run();
        test_timing();
        test_handshake();
        test_pacing();
        test_reset_mid_run();
        test_small_window();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_spike_rate_encoder
`default_nettype wire
